apb_slave_regfile: RTL and testbench
====================================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter SEL_INDEX, default 0: the bit of Pselx that selects this responder.
REQ-002 SHALL have parameter WAIT_STATES, default 1: ACCESS cycles with Pready low before completion, range 0..15.
REQ-003 SHALL have parameter ID_VALUE, default 32'hA2B0_0012: read-only contents of register 0.
REQ-004 SHALL have port Hclk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Hreset  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port Pselx  input  3: one-hot peripheral select from the bridge.
REQ-007 SHALL have port Penable  input  1: APB access-phase strobe.
REQ-008 SHALL have port Pwrite  input  1: 1 = write, 0 = read.
REQ-009 SHALL have port Paddr  input  32: byte address; bits [4:2] form the register index.
REQ-010 SHALL have port Pwdata  input  32: write data.
REQ-011 SHALL have port Prdata  output  32: read data, nonzero only in a completing read cycle.
REQ-012 SHALL have port Pready  output  1: transfer-completion strobe.
REQ-013 SHALL have port Pslverr  output  1: error response, valid only while Pready=1.

Function
REQ-014 SHALL define sel = Pselx[SEL_INDEX] and SHALL ignore the other Pselx bits.
REQ-015 SHALL implement an FSM with states IDLE and ACCESS.
REQ-016 SHALL, in IDLE when sel=1 and Penable=0 (setup phase), latch Paddr, Pwrite and Pwdata, load wait_cnt=WAIT_STATES and go to ACCESS; all other IDLE inputs keep IDLE.
REQ-017 SHALL, in ACCESS while wait_cnt>0, drive Pready=0 and decrement wait_cnt each cycle.
REQ-018 SHALL, in ACCESS with wait_cnt=0, sel=1 and Penable=1, drive Pready=1 combinationally, complete the transfer and return to IDLE at the next edge.
REQ-019 SHALL give the transfer a latency of WAIT_STATES+1 cycles after the setup cycle; with WAIT_STATES=0, Pready rises in the first ACCESS cycle.
REQ-020 SHALL abort when sel=0 or Penable=0 in any ACCESS cycle before completion: return to IDLE, perform no write, and set status bit STAT[0].
REQ-021 SHALL decode an error when Paddr[1:0]!=0 or Paddr[11:5]!=0; on error, Pslverr=1 in the completing cycle, writes are discarded and Prdata=0.
REQ-022 SHALL map register 0 as ID: reads return ID_VALUE; writes give Pslverr=1 and leave it unchanged.
REQ-023 SHALL map register 1 as STAT: bit0 is the sticky abort flag, cleared by writing 1 to bit0; the other bits read 0.
REQ-024 SHALL map registers 2..7 as 32-bit read/write; a write takes effect at the edge ending the completing cycle.
REQ-025 SHALL, for a read, drive the latched register value on Prdata only while Pready=1 and Pwrite=0, and 0 otherwise.
REQ-026 SHALL give an abort in the same cycle as a W1C write priority for the set; STAT[0] remains 1.
REQ-027 SHALL allow back-to-back transfers: a new setup phase is accepted in the IDLE cycle immediately following completion.
REQ-028 SHALL drive Pready=0 and Pslverr=0 outside completing cycles.

Reset
REQ-029 SHALL, while Hreset=1 at a clock edge, set state=IDLE, wait_cnt=0, registers 2..7=0 and STAT=0.
REQ-030 SHALL hold Pready=0, Pslverr=0 and Prdata=0 during reset.
REQ-031 SHALL, on reset mid-ACCESS, discard the pending transfer with no write and no STAT flag set.

Structure
REQ-032 SHALL place the state enum (IDLE, ACCESS), register index constants (REG_ID=0, REG_STAT=1) and the default ID constant in package apb_regfile_pkg.
REQ-033 SHALL implement the loadable down-counter as sub-module apb_wait_counter, with load, value and zero-flag ports; everything else stays in apb_slave_regfile.

Verification
REQ-034 SHALL cover: WAIT_STATES=1, write 0x0000_0008 with data 0xDEAD_BEEF, then read 0x0000_0008 -> Pready high 2 cycles after each setup, Prdata=0xDEAD_BEEF, Pslverr=0.
REQ-035 SHALL cover: read 0x0000_0000 -> Prdata=0xA2B0_0012; write 0x0000_0000 -> Pslverr=1, and a following read is still 0xA2B0_0012.
REQ-036 SHALL cover: read 0x0000_0022 and write 0x0000_0040 -> Pslverr=1, Prdata=0, and registers 2..7 unchanged.
REQ-037 SHALL cover: write 0x0000_000C but drop Penable during the wait cycle -> no write (read of 0x0C returns 0), then read 0x04 -> Prdata=0x1, then write 0x1 to 0x04 -> next read 0x0.
REQ-038 SHALL cover: WAIT_STATES=0, back-to-back writes to 0x08 and 0x10 followed by reads -> Pready in each ACCESS cycle, with the correct values returned.
REQ-039 SHALL cover: Hreset asserted mid-ACCESS of a write to 0x14 -> Pready=0 and register 0x14 reads 0 after reset.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// rtl/apb_regfile_pkg.sv - shared FSM states, register map and ID constant for the APB register file
package apb_regfile_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [2:0]  REG_ID       = 3'd0;
  localparam logic [2:0]  REG_STAT     = 3'd1;
  localparam logic [2:0]  REG_FIRST_RW = 3'd2;
  localparam logic [2:0]  REG_LAST_RW  = 3'd7;
  localparam logic [31:0] ID_DEFAULT   = 32'hA2B0_0012;
  localparam int          WAIT_W       = 4;

  // Only word-aligned offsets inside the 32-byte window decode to a register.
  function automatic logic addr_is_bad(input logic [11:0] addr);
    return (addr[1:0] != 2'b00) || (addr[11:5] != 7'd0);
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// rtl/apb_wait_counter.sv - loadable down-counter that paces ACCESS wait states
module apb_wait_counter
  import apb_regfile_pkg::*;
#(
  parameter int WIDTH = WAIT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_value;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB responder: read-only ID, sticky abort status, six read/write registers
module apb_slave_regfile
  import apb_regfile_pkg::*;
#(
  parameter int unsigned SEL_INDEX   = 0,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam logic [1:0]        SEL_BIT   = SEL_INDEX[1:0];
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

  state_e      r_state;
  logic [11:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_regs [REG_FIRST_RW:REG_LAST_RW];
  logic        r_stat_abort;

  logic              w_sel;
  logic              w_setup;
  logic              w_in_access;
  logic              w_abort;
  logic              w_complete;
  logic              w_cnt_zero;
  logic              w_addr_err;
  logic              w_slverr;
  logic              w_wr_en;
  logic [2:0]        w_idx;
  logic [31:0]       w_rd_value;
  logic [WAIT_W-1:0] w_unused_cnt;
  logic              w_unused_bits;

  assign w_sel         = Pselx[SEL_BIT];
  assign w_unused_bits = ^{Paddr[31:12], Pselx};

  assign w_in_access = (r_state == ACCESS);
  assign w_setup     = !Hreset && (r_state == IDLE) && w_sel && !Penable;
  assign w_abort     = w_in_access && !(w_sel && Penable);
  assign w_complete  = !Hreset && w_in_access && w_cnt_zero && w_sel && Penable;

  assign w_idx      = r_addr[4:2];
  assign w_addr_err = addr_is_bad(r_addr);
  // The ID register is read-only, so a write to it is reported like a decode error.
  assign w_slverr   = w_addr_err || (r_write && (w_idx == REG_ID));
  assign w_wr_en    = w_complete && r_write && !w_slverr;

  apb_wait_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_counter (
    .i_clk        (Hclk),
    .i_reset      (Hreset),
    .i_load       (w_setup),
    .i_load_value (WAIT_LOAD),
    .i_dec        (w_in_access),
    .o_value      (w_unused_cnt),
    .o_zero       (w_cnt_zero)
  );

  always_comb begin
    w_rd_value = '0;
    case (w_idx)
      REG_ID:   w_rd_value = ID_VALUE;
      REG_STAT: w_rd_value = {31'd0, r_stat_abort};
      default:  w_rd_value = r_regs[w_idx];
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_stat_abort <= 1'b0;
      for (int i = 2; i < 8; i++) begin
        r_regs[3'(i)] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= ACCESS;
            r_addr  <= Paddr[11:0];
            r_write <= Pwrite;
            r_wdata <= Pwdata;
          end
        end
        ACCESS: begin
          if (w_abort || w_complete) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_wr_en && (w_idx >= REG_FIRST_RW)) begin
        r_regs[w_idx] <= r_wdata;
      end

      // A same-cycle abort wins over a write-one-to-clear.
      if (w_abort) begin
        r_stat_abort <= 1'b1;
      end else if (w_wr_en && (w_idx == REG_STAT) && r_wdata[0]) begin
        r_stat_abort <= 1'b0;
      end
    end
  end

  assign Pready  = w_complete;
  assign Pslverr = w_complete && w_slverr;
  assign Prdata  = (w_complete && !r_write && !w_slverr) ? w_rd_value : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed plus randomized bench for two responders with 1 and 0 wait states
module tb_apb_slave_regfile;

  localparam logic [31:0] ID_CONST = 32'hA2B0_0012;

  logic        Hclk;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  logic [1:0]       rdy;
  logic [1:0]       serr;
  logic [1:0][31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [2][8];
  logic        m_stat [2];

  apb_slave_regfile #(
    .SEL_INDEX   (0),
    .WAIT_STATES (1),
    .ID_VALUE    (32'hA2B0_0012)
  ) u_dut_ws1 (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Pselx   (Pselx),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (rdata[0]),
    .Pready  (rdy[0]),
    .Pslverr (serr[0])
  );

  apb_slave_regfile #(
    .SEL_INDEX   (2),
    .WAIT_STATES (0),
    .ID_VALUE    (32'hA2B0_0012)
  ) u_dut_ws0 (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Pselx   (Pselx),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (rdata[1]),
    .Pready  (rdy[1]),
    .Pslverr (serr[1])
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sel_mask(input int tgt);
    logic [2:0] m;
    m = (tgt == 0) ? 3'b001 : 3'b100;
    m[1] = 1'($urandom_range(0, 1));
    return m;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      m_stat[t] = 1'b0;
      for (int r = 0; r < 8; r++) m_regs[t][r] = '0;
    end
  endtask

  task automatic xfer(input int tgt, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int          ws;
    int          cyc;
    bit          seen;
    int          idx;
    bit          bad;
    bit          exp_err;
    logic [31:0] exp_rd;
    ws      = (tgt == 0) ? 1 : 0;
    idx     = int'(addr[4:2]);
    bad     = (addr[1:0] != 2'b00) || (addr[11:5] != 7'd0);
    exp_err = bad || (wr && idx == 0);
    exp_rd  = '0;
    if (!wr && !bad) begin
      if (idx == 0)      exp_rd = ID_CONST;
      else if (idx == 1) exp_rd = {31'd0, m_stat[tgt]};
      else               exp_rd = m_regs[tgt][idx];
    end
    @(posedge Hclk); #1;
    Pselx = sel_mask(tgt); Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      cyc++;
      @(negedge Hclk);
      if (rdy[tgt]) begin
        seen = 1;
      end else begin
        check("wait_slverr", 32'(serr[tgt]), 32'd0);
        check("wait_prdata", rdata[tgt], 32'd0);
        @(posedge Hclk); #1;
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(cyc), 32'(ws + 1));
      check("slverr", 32'(serr[tgt]), 32'(exp_err));
      check("prdata", rdata[tgt], exp_rd);
      check("other_quiet", 32'(rdy[1 - tgt]), 32'd0);
    end
    if (wr && !exp_err) begin
      if (idx == 1) begin
        if (data[0]) m_stat[tgt] = 1'b0;
      end else begin
        m_regs[tgt][idx] = data;
      end
    end
  endtask

  task automatic abort_xfer(input int tgt, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input bit drop_sel);
    @(posedge Hclk); #1;
    Pselx = sel_mask(tgt); Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
    @(posedge Hclk); #1;
    if (drop_sel) begin
      Pselx   = 3'b010;
      Penable = 1'b1;
    end
    @(negedge Hclk);
    check("abort_ready", 32'(rdy[tgt]), 32'd0);
    check("abort_slverr", 32'(serr[tgt]), 32'd0);
    @(posedge Hclk); #1;
    Pselx   = 3'b000;
    Penable = 1'b0;
    m_stat[tgt] = 1'b1;
  endtask

  task automatic readback_all(input int tgt);
    for (int r = 2; r < 8; r++) xfer(tgt, 1'b0, 32'(r * 4), 32'd0);
  endtask

  initial begin
    int          tgt;
    int          kind;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;

    Hreset = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    model_reset();
    @(posedge Hclk); @(posedge Hclk);
    @(negedge Hclk);
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_slverr", 32'(serr), 32'd0);
    check("rst_prdata_a", rdata[0], 32'd0);
    check("rst_prdata_b", rdata[1], 32'd0);
    @(posedge Hclk); #1;
    Hreset = 1'b0;

    xfer(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h0000_0008, 32'd0);

    xfer(0, 1'b0, 32'h0000_0000, 32'd0);
    xfer(0, 1'b1, 32'h0000_0000, 32'h1234_5678);
    xfer(0, 1'b0, 32'h0000_0000, 32'd0);

    xfer(0, 1'b0, 32'h0000_0022, 32'd0);
    xfer(0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF);
    readback_all(0);

    abort_xfer(0, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 1'b0);
    xfer(0, 1'b0, 32'h0000_000C, 32'd0);
    xfer(0, 1'b0, 32'h0000_0004, 32'd0);
    xfer(0, 1'b1, 32'h0000_0004, 32'h0000_0001);
    xfer(0, 1'b0, 32'h0000_0004, 32'd0);

    xfer(1, 1'b1, 32'h0000_0008, 32'h1111_2222);
    xfer(1, 1'b1, 32'h0000_0010, 32'h3333_4444);
    xfer(1, 1'b0, 32'h0000_0008, 32'd0);
    xfer(1, 1'b0, 32'h0000_0010, 32'd0);

    for (int n = 0; n < 80; n++) begin
      tgt  = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      wr   = 1'($urandom_range(0, 1));
      data = $urandom;
      addr = {20'($urandom), 7'd0, 3'($urandom_range(0, 7)), 2'b00};
      if (kind == 0) addr[1:0]  = 2'($urandom_range(1, 3));
      if (kind == 1) addr[11:5] = 7'($urandom_range(1, 127));
      if (kind == 2) abort_xfer(tgt, wr, addr, data, 1'($urandom_range(0, 1)));
      else           xfer(tgt, wr, addr, data);
    end
    readback_all(0);
    readback_all(1);
    xfer(0, 1'b0, 32'h0000_0004, 32'd0);
    xfer(1, 1'b0, 32'h0000_0004, 32'd0);

    xfer(0, 1'b1, 32'h0000_0014, 32'h5A5A_A5A5);
    @(posedge Hclk); #1;
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0000_0014; Pwdata = 32'h0BAD_0BAD;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    Hreset  = 1'b1;
    @(negedge Hclk);
    check("rst_mid_ready", 32'(rdy), 32'd0);
    check("rst_mid_slverr", 32'(serr), 32'd0);
    check("rst_mid_prdata", rdata[0], 32'd0);
    @(posedge Hclk); #1;
    Pselx = 3'b000; Penable = 1'b0;
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    model_reset();
    xfer(0, 1'b0, 32'h0000_0014, 32'd0);
    xfer(0, 1'b0, 32'h0000_0004, 32'd0);
    xfer(1, 1'b0, 32'h0000_0008, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
